riscv_instr_realigner: RTL and testbench

Sequencing stage between the prefetch buffer and the compressed instruction decoder. It consumes in-order, word-aligned 32-bit fetch words and delivers one instruction per handshake, 16-bit or 32-bit, always bit-0 aligned, together with its PC. It stitches 32-bit instructions that straddle two fetch words and keeps the leftover upper halfword in a residual register. It also handles branch targets at halfword offsets.

---
 rtl/riscv_instr_realigner_if.sv | 28 ++
 rtl/riscv_instr_realigner.sv | 183 ++++++++++++++++++
 tb/tb_riscv_instr_realigner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/riscv_instr_realigner_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_instr_realigner_if
// Description : Fetch-side and decode-side handshake bundle of the realigner.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_instr_realigner_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_ready_i;

    modport master (
        output fetch_valid_i, fetch_rdata_i, branch_i, branch_addr_i, instr_ready_i,
        input  fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o
    );

    modport slave (
        input  fetch_valid_i, fetch_rdata_i, branch_i, branch_addr_i, instr_ready_i,
        output fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/riscv_instr_realigner.sv
`default_nettype none
// ============================================================================
// Module      : riscv_instr_realigner
// Description : Turns word-aligned fetch words into bit-0 aligned 16/32-bit
//               instructions with their PC. Compressed support is enabled by
//               defining RV_COMPRESSED_EN; otherwise every word is 32-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_instr_realigner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    riscv_instr_realigner_if.slave  bus
);

    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_rdata;

`ifdef RV_COMPRESSED_EN

    localparam logic [1:0]  c_ST_ALIGNED    = 2'd0;
    localparam logic [1:0]  c_ST_MISALIGNED = 2'd1;
    localparam logic [1:0]  c_ST_BRANCH_MIS = 2'd2;
    localparam logic [31:0] c_BOOT_PC       = {BOOT_ADDR[31:1], 1'b0};
    localparam logic [1:0]  c_BOOT_STATE    = BOOT_ADDR[1] ? c_ST_BRANCH_MIS : c_ST_ALIGNED;

    logic [1:0]  r_state;
    logic [15:0] r_resid;
    logic [31:0] r_pc;

    logic        w_lo_is_c;
    logic        w_res_is_c;
    logic        w_raw_valid;
    logic        w_consume;
    logic        w_xfer;
    logic [31:0] w_target;

    assign w_lo_is_c  = (bus.fetch_rdata_i[1:0] != 2'b11);
    assign w_res_is_c = (r_resid[1:0] != 2'b11);
    assign w_xfer     = w_raw_valid && bus.instr_ready_i;
    // Bit 0 of a branch target carries no meaning for halfword-aligned code.
    assign w_target   = {bus.branch_addr_i[31:1], bus.branch_addr_i[0] & 1'b0};

    always_comb begin
        w_raw_valid = 1'b0;
        w_consume   = 1'b0;
        w_rdata     = 32'h0;
        w_ready     = 1'b0;
        case (r_state)
            c_ST_ALIGNED: begin
                w_raw_valid = bus.fetch_valid_i;
                w_consume   = 1'b1;
                w_rdata     = w_lo_is_c ? {16'h0, bus.fetch_rdata_i[15:0]} : bus.fetch_rdata_i;
            end
            c_ST_MISALIGNED: begin
                if (w_res_is_c) begin
                    w_raw_valid = 1'b1;
                    w_rdata     = {16'h0, r_resid};
                end else begin
                    w_raw_valid = bus.fetch_valid_i;
                    w_consume   = 1'b1;
                    w_rdata     = {bus.fetch_rdata_i[15:0], r_resid};
                end
            end
            c_ST_BRANCH_MIS: begin
                w_ready = bus.fetch_valid_i;
            end
            default: begin
                w_raw_valid = 1'b0;
            end
        endcase

        if (w_consume)
            w_ready = w_xfer;
        w_valid = w_raw_valid;

        // A redirect flushes whatever the fetch side presents this cycle.
        if (bus.branch_i) begin
            w_valid = 1'b0;
            w_ready = 1'b1;
        end

        if (!rst_n) begin
            w_valid = 1'b0;
            w_ready = 1'b0;
            w_rdata = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_BOOT_STATE;
            r_pc    <= c_BOOT_PC;
            r_resid <= 16'h0;
        end else if (bus.branch_i) begin
            r_state <= bus.branch_addr_i[1] ? c_ST_BRANCH_MIS : c_ST_ALIGNED;
            r_pc    <= w_target;
            r_resid <= 16'h0;
        end else begin
            case (r_state)
                c_ST_ALIGNED: begin
                    if (w_xfer) begin
                        if (w_lo_is_c) begin
                            r_resid <= bus.fetch_rdata_i[31:16];
                            r_pc    <= r_pc + 32'd2;
                            r_state <= c_ST_MISALIGNED;
                        end else begin
                            r_pc    <= r_pc + 32'd4;
                        end
                    end
                end
                c_ST_MISALIGNED: begin
                    if (w_xfer) begin
                        if (w_res_is_c) begin
                            r_pc    <= r_pc + 32'd2;
                            r_state <= c_ST_ALIGNED;
                        end else begin
                            r_resid <= bus.fetch_rdata_i[31:16];
                            r_pc    <= r_pc + 32'd4;
                        end
                    end
                end
                c_ST_BRANCH_MIS: begin
                    // The lower halfword precedes the target and is dropped.
                    if (bus.fetch_valid_i) begin
                        r_resid <= bus.fetch_rdata_i[31:16];
                        r_state <= c_ST_MISALIGNED;
                    end
                end
                default: begin
                    r_state <= c_ST_ALIGNED;
                end
            endcase
        end
    end

`else

    localparam logic [31:0] c_BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

    logic [31:0] r_pc;
    logic        w_xfer;
    logic [31:0] w_target;

    assign w_xfer   = bus.fetch_valid_i && bus.instr_ready_i;
    // Without compressed code every target is word aligned.
    assign w_target = {bus.branch_addr_i[31:2], bus.branch_addr_i[1:0] & 2'b00};

    always_comb begin
        w_valid = 1'b0;
        w_ready = 1'b0;
        w_rdata = 32'h0;
        if (rst_n) begin
            w_rdata = bus.fetch_rdata_i;
            if (bus.branch_i) begin
                w_ready = 1'b1;
            end else begin
                w_valid = bus.fetch_valid_i;
                w_ready = w_xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pc <= c_BOOT_PC;
        else if (bus.branch_i)
            r_pc <= w_target;
        else if (w_xfer)
            r_pc <= r_pc + 32'd4;
    end

`endif

    assign bus.instr_valid_o = w_valid;
    assign bus.instr_rdata_o = w_rdata;
    assign bus.instr_addr_o  = r_pc;
    assign bus.fetch_ready_o = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_realigner.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_instr_realigner
// Description : Directed self-checking bench for riscv_instr_realigner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_instr_realigner;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    riscv_instr_realigner_if bus();

    riscv_instr_realigner #(.BOOT_ADDR(32'h0000_0080)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.branch_i = 1'b0; bus.branch_addr_i = 32'h0;
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'h00A00093; bus.instr_ready_i = 1'b1;
        step(); step(); #1;
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", bus.instr_valid_o); end
        total++; if (bus.fetch_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0h want 0", bus.fetch_ready_o); end
        total++; if (bus.instr_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", bus.instr_rdata_o); end
        rst_n = 1'b1; #1;
        total++; if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL first_valid: got %0h want 1", bus.instr_valid_o); end
        total++; if (bus.instr_rdata_o !== 32'h00A00093) begin bad++; $display("FAIL first_rdata: got %h want 00a00093", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h80) begin bad++; $display("FAIL first_addr: got %h want 00000080", bus.instr_addr_o); end
        total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL first_ready: got %0h want 1", bus.fetch_ready_o); end
        step(); bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_addr_o !== 32'h84) begin bad++; $display("FAIL first_pc_next: got %h want 00000084", bus.instr_addr_o); end
    endtask

    task automatic test_compressed_pair();
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'h00010001; bus.instr_ready_i = 1'b1; #1;
`ifdef RV_COMPRESSED_EN
        total++; if (bus.instr_rdata_o !== 32'h1) begin bad++; $display("FAIL pair_lo_rdata: got %h want 00000001", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h84) begin bad++; $display("FAIL pair_lo_addr: got %h want 00000084", bus.instr_addr_o); end
        total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL pair_lo_ready: got %0h want 1", bus.fetch_ready_o); end
        step(); #1;
        total++; if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL pair_hi_valid: got %0h want 1", bus.instr_valid_o); end
        total++; if (bus.instr_rdata_o !== 32'h1) begin bad++; $display("FAIL pair_hi_rdata: got %h want 00000001", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h86) begin bad++; $display("FAIL pair_hi_addr: got %h want 00000086", bus.instr_addr_o); end
        total++; if (bus.fetch_ready_o !== 1'b0) begin bad++; $display("FAIL pair_hi_ready: got %0h want 0", bus.fetch_ready_o); end
        step(); bus.fetch_valid_i = 1'b0; #1;
`else
        total++; if (bus.instr_rdata_o !== 32'h00010001) begin bad++; $display("FAIL pair_off_rdata: got %h want 00010001", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h84) begin bad++; $display("FAIL pair_off_addr: got %h want 00000084", bus.instr_addr_o); end
        total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL pair_off_ready: got %0h want 1", bus.fetch_ready_o); end
        step(); bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL pair_off_idle_valid: got %0h want 0", bus.instr_valid_o); end
`endif
        total++; if (bus.instr_addr_o !== 32'h88) begin bad++; $display("FAIL pair_pc_next: got %h want 00000088", bus.instr_addr_o); end
    endtask

    task automatic test_straddle();
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'h00934505; bus.instr_ready_i = 1'b1; #1;
`ifdef RV_COMPRESSED_EN
        total++; if (bus.instr_rdata_o !== 32'h00004505) begin bad++; $display("FAIL strad_c_rdata: got %h want 00004505", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h88) begin bad++; $display("FAIL strad_c_addr: got %h want 00000088", bus.instr_addr_o); end
        step(); bus.fetch_rdata_i = 32'h12340513; #1;
        total++; if (bus.instr_rdata_o !== 32'h05130093) begin bad++; $display("FAIL strad_w_rdata: got %h want 05130093", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h8A) begin bad++; $display("FAIL strad_w_addr: got %h want 0000008a", bus.instr_addr_o); end
        total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL strad_w_ready: got %0h want 1", bus.fetch_ready_o); end
        step(); bus.fetch_valid_i = 1'b0; bus.instr_ready_i = 1'b0; #1;
        total++; if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL strad_res_valid: got %0h want 1", bus.instr_valid_o); end
        total++; if (bus.instr_rdata_o !== 32'h00001234) begin bad++; $display("FAIL strad_res_rdata: got %h want 00001234", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h8E) begin bad++; $display("FAIL strad_res_addr: got %h want 0000008e", bus.instr_addr_o); end
`else
        total++; if (bus.instr_rdata_o !== 32'h00934505) begin bad++; $display("FAIL seq_w0_rdata: got %h want 00934505", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h88) begin bad++; $display("FAIL seq_w0_addr: got %h want 00000088", bus.instr_addr_o); end
        step(); bus.fetch_rdata_i = 32'h12340513; #1;
        total++; if (bus.instr_rdata_o !== 32'h12340513) begin bad++; $display("FAIL seq_w1_rdata: got %h want 12340513", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h8C) begin bad++; $display("FAIL seq_w1_addr: got %h want 0000008c", bus.instr_addr_o); end
        step(); bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_addr_o !== 32'h90) begin bad++; $display("FAIL seq_pc_next: got %h want 00000090", bus.instr_addr_o); end
`endif
    endtask

    task automatic test_halfword_branch();
        bus.branch_i = 1'b1; bus.branch_addr_i = 32'h102; bus.instr_ready_i = 1'b1;
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'hDEADBEEF; #1;
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL br_valid: got %0h want 0", bus.instr_valid_o); end
        total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL br_ready: got %0h want 1", bus.fetch_ready_o); end
        step(); bus.branch_i = 1'b0; bus.fetch_rdata_i = 32'h45050001; #1;
`ifdef RV_COMPRESSED_EN
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL brmis_valid: got %0h want 0", bus.instr_valid_o); end
        total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL brmis_ready: got %0h want 1", bus.fetch_ready_o); end
        step(); bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL brtgt_valid: got %0h want 1", bus.instr_valid_o); end
        total++; if (bus.instr_rdata_o !== 32'h00004505) begin bad++; $display("FAIL brtgt_rdata: got %h want 00004505", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h102) begin bad++; $display("FAIL brtgt_addr: got %h want 00000102", bus.instr_addr_o); end
`else
        total++; if (bus.instr_rdata_o !== 32'h45050001) begin bad++; $display("FAIL brtgt_off_rdata: got %h want 45050001", bus.instr_rdata_o); end
        total++; if (bus.instr_addr_o !== 32'h100) begin bad++; $display("FAIL brtgt_off_addr: got %h want 00000100", bus.instr_addr_o); end
        bus.fetch_valid_i = 1'b1;
`endif
        step(); bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_addr_o !== 32'h104) begin bad++; $display("FAIL br_pc_next: got %h want 00000104", bus.instr_addr_o); end
    endtask

    task automatic test_stall_and_branch();
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'h00B00113; bus.instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.instr_rdata_o !== 32'h00B00113 || bus.instr_valid_o !== 1'b1)
                begin bad++; $display("FAIL stall_out[%0d]: got %h/%0h want 00b00113/1", i, bus.instr_rdata_o, bus.instr_valid_o); end
            total++; if (bus.instr_addr_o !== 32'h104 || bus.fetch_ready_o !== 1'b0)
                begin bad++; $display("FAIL stall_hold[%0d]: got %h/%0h want 00000104/0", i, bus.instr_addr_o, bus.fetch_ready_o); end
            step();
        end
        bus.branch_i = 1'b1; bus.branch_addr_i = 32'h200; bus.instr_ready_i = 1'b1; #1;
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL coll_valid: got %0h want 0", bus.instr_valid_o); end
        step(); bus.branch_i = 1'b0; bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_addr_o !== 32'h200) begin bad++; $display("FAIL coll_pc: got %h want 00000200", bus.instr_addr_o); end
    endtask

    task automatic test_pc_wrap();
        bus.branch_i = 1'b1; bus.branch_addr_i = 32'hFFFF_FFFC;
        step(); bus.branch_i = 1'b0;
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'h00000013; bus.instr_ready_i = 1'b1; #1;
        total++; if (bus.instr_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h want fffffffc", bus.instr_addr_o); end
        step(); bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 00000000", bus.instr_addr_o); end
    endtask

    task automatic test_reset_mid_stall();
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'h00010001; bus.instr_ready_i = 1'b1;
        step(); bus.instr_ready_i = 1'b0; rst_n = 1'b0;
        step(); rst_n = 1'b1; bus.fetch_valid_i = 1'b0; #1;
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_stall_valid: got %0h want 0", bus.instr_valid_o); end
        total++; if (bus.instr_addr_o !== 32'h80) begin bad++; $display("FAIL rst_stall_addr: got %h want 00000080", bus.instr_addr_o); end
    endtask

    initial begin
        test_reset();
        test_compressed_pair();
        test_straddle();
        test_halfword_branch();
        test_stall_and_branch();
        test_pc_wrap();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
